i2c_target_rx: RTL and testbench

//  Write-only I2C target (receiver) for the far end of the I2C4BYTES bus master.

---
 rtl/i2c_target_rx.sv | 178 +++++++++++++++++
 tb/tb_i2c_target_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: filtered SCL/SDA sampling, address match, ACK generation and byte strobe.
// Optional macro I2C_TGT_FRAME_EN adds a 24-bit assembler of the first three data bytes.
module i2c_target_rx #(
    parameter logic [6:0] ADDR     = 7'h42,
    parameter int         FILT_LEN = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_PULL,
    output logic [7:0]  RXDATA,
    output logic        RXVALID,
    output logic [7:0]  RXCOUNT,
    output logic        ADDRHIT,
    output logic        BUSY
`ifdef I2C_TGT_FRAME_EN
    ,
    output logic [23:0] FRAME,
    output logic        FRAMEVALID
`endif
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDRS    = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    // Bit 1 carries SCL, bit 0 carries SDA through the whole input path.
    logic [1:0] meta, sync, filt, filt_d;
    logic [3:0] fcnt [2];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= 4'd0;
            fcnt[1] <= 4'd0;
        end else begin
            meta   <= {SCL_IN, SDA_IN};
            sync   <= meta;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= 4'd0;
                end else if (fcnt[i] == FILT_MAX) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= 4'd0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic scl, scl_d, sda, sda_d;
    logic sclr, sclf, start_ev, stop_ev;
    assign scl      = filt[1];
    assign scl_d    = filt_d[1];
    assign sda      = filt[0];
    assign sda_d    = filt_d[0];
    assign sclr     = scl & ~scl_d;
    assign sclf     = ~scl & scl_d;
    assign start_ev = scl & scl_d & sda_d & ~sda;
    assign stop_ev  = scl & scl_d & ~sda_d & sda;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] next_byte;
    assign next_byte = {shreg[6:0], sda};

`ifdef I2C_TGT_FRAME_EN
    logic [15:0] frame_sh;
    logic [1:0]  frame_cnt;
`endif

    // START/STOP override every state; otherwise the FSM advances on SCL edges.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            SDA_PULL <= 1'b0;
            RXDATA   <= 8'd0;
            RXVALID  <= 1'b0;
            RXCOUNT  <= 8'd0;
            ADDRHIT  <= 1'b0;
            BUSY     <= 1'b0;
`ifdef I2C_TGT_FRAME_EN
            frame_sh   <= 16'd0;
            frame_cnt  <= 2'd0;
            FRAME      <= 24'd0;
            FRAMEVALID <= 1'b0;
`endif
        end else begin
            RXVALID <= 1'b0;
`ifdef I2C_TGT_FRAME_EN
            FRAMEVALID <= 1'b0;
`endif
            if (stop_ev) begin
                state    <= IDLE;
                SDA_PULL <= 1'b0;
                BUSY     <= 1'b0;
                ADDRHIT  <= 1'b0;
`ifdef I2C_TGT_FRAME_EN
                frame_cnt <= 2'd0;
`endif
            end else if (start_ev) begin
                state    <= ADDRS;
                bit_cnt  <= 3'd0;
                RXCOUNT  <= 8'd0;
                ADDRHIT  <= 1'b0;
                SDA_PULL <= 1'b0;
                BUSY     <= 1'b1;
`ifdef I2C_TGT_FRAME_EN
                frame_cnt <= 2'd0;
`endif
            end else begin
                case (state)
                    ADDRS: begin
                        if (sclr) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= (next_byte == {ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First SCL fall opens the ACK slot, the second one closes it.
                        if (sclf) begin
                            if (!SDA_PULL) begin
                                SDA_PULL <= 1'b1;
                            end else begin
                                SDA_PULL <= 1'b0;
                                bit_cnt  <= 3'd0;
                                state    <= DATA;
                                if (state == ADDR_ACK)
                                    ADDRHIT <= 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (sclr) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                RXDATA  <= next_byte;
                                RXVALID <= 1'b1;
                                if (RXCOUNT != 8'hFF)
                                    RXCOUNT <= RXCOUNT + 8'd1;
                                state <= DATA_ACK;
`ifdef I2C_TGT_FRAME_EN
                                if (frame_cnt != 2'd3) begin
                                    frame_cnt <= frame_cnt + 2'd1;
                                    frame_sh  <= {frame_sh[7:0], next_byte};
                                    if (frame_cnt == 2'd2) begin
                                        FRAME      <= {frame_sh, next_byte};
                                        FRAMEVALID <= 1'b1;
                                    end
                                end
`endif
                            end
                        end
                    end
                    default: SDA_PULL <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: drives a bit-banged I2C master and checks ACKs, bytes and flags.
// Define I2C_TGT_FRAME_EN to also exercise the frame assembler.
module tb_i2c_target_rx;

    logic        CLK;
    logic        RESET;
    logic        scl_drv, sda_drv;
    logic        SDA_PULL;
    logic [7:0]  RXDATA;
    logic        RXVALID;
    logic [7:0]  RXCOUNT;
    logic        ADDRHIT;
    logic        BUSY;
`ifdef I2C_TGT_FRAME_EN
    logic [23:0] FRAME;
    logic        FRAMEVALID;
`endif

    logic sda_bus;
    assign sda_bus = sda_drv & ~SDA_PULL;

    i2c_target_rx #(.ADDR(7'h42), .FILT_LEN(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .SCL_IN(scl_drv),
        .SDA_IN(sda_bus),
        .SDA_PULL(SDA_PULL),
        .RXDATA(RXDATA),
        .RXVALID(RXVALID),
        .RXCOUNT(RXCOUNT),
        .ADDRHIT(ADDRHIT),
        .BUSY(BUSY)
`ifdef I2C_TGT_FRAME_EN
        ,
        .FRAME(FRAME),
        .FRAMEVALID(FRAMEVALID)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int pull_cnt = 0;
    int fv_cnt = 0;

    // Event monitors only ever count up; the stimulus takes snapshots to get per-transfer deltas.
    always @(posedge CLK) begin
        if (RXVALID === 1'b1) valid_cnt <= valid_cnt + 1;
        if (SDA_PULL === 1'b1) pull_cnt <= pull_cnt + 1;
`ifdef I2C_TGT_FRAME_EN
        if (FRAMEVALID === 1'b1) fv_cnt <= fv_cnt + 1;
`endif
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(20);
        sda_drv = 1'b0;
        wait_clk(20);
        scl_drv = 1'b0;
        wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(20);
        sda_drv = 1'b1;
        wait_clk(20);
    endtask

    task automatic i2c_bit(input logic b);
        sda_drv = b;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(20);
        scl_drv = 1'b0;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        sda_drv = 1'b1;
        wait_clk(10);
        scl_drv = 1'b1;
        wait_clk(10);
        ack = SDA_PULL;
        wait_clk(10);
        scl_drv = 1'b0;
        wait_clk(10);
    endtask

    logic ack;
    int   v0, p0, f0;

    initial begin
        RESET   = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_clk(3);
        check_output("reset_pull", 32'(SDA_PULL), 32'd0);
        check_output("reset_rxdata", 32'(RXDATA), 32'd0);
        check_output("reset_rxvalid", 32'(RXVALID), 32'd0);
        check_output("reset_rxcount", 32'(RXCOUNT), 32'd0);
        check_output("reset_addrhit", 32'(ADDRHIT), 32'd0);
        check_output("reset_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        wait_clk(10);

        $display("[TB] matched write 0x84, 0xA5");
        v0 = valid_cnt;
        i2c_start();
        check_output("t1_busy", 32'(BUSY), 32'd1);
        send_byte(8'h84, ack);
        check_output("t1_addr_ack", 32'(ack), 32'd1);
        check_output("t1_addrhit", 32'(ADDRHIT), 32'd1);
        send_byte(8'hA5, ack);
        check_output("t1_data_ack", 32'(ack), 32'd1);
        check_output("t1_rxdata", 32'(RXDATA), 32'hA5);
        check_output("t1_rxcount", 32'(RXCOUNT), 32'd1);
        check_output("t1_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        i2c_stop();
        check_output("t1_busy_after_stop", 32'(BUSY), 32'd0);
        check_output("t1_addrhit_after_stop", 32'(ADDRHIT), 32'd0);
        check_output("t1_rxcount_hold", 32'(RXCOUNT), 32'd1);
        check_output("t1_pull_released", 32'(SDA_PULL), 32'd0);

        $display("[TB] wrong address 0x86");
        v0 = valid_cnt;
        p0 = pull_cnt;
        i2c_start();
        send_byte(8'h86, ack);
        check_output("t2_addr_nack", 32'(ack), 32'd0);
        send_byte(8'h11, ack);
        check_output("t2_data_nack", 32'(ack), 32'd0);
        check_output("t2_addrhit", 32'(ADDRHIT), 32'd0);
        check_output("t2_rxcount", 32'(RXCOUNT), 32'd0);
        i2c_stop();
        check_output("t2_pull_cycles", 32'(pull_cnt - p0), 32'd0);
        check_output("t2_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        check_output("t2_rxdata_hold", 32'(RXDATA), 32'hA5);

        $display("[TB] read request 0x85");
        p0 = pull_cnt;
        i2c_start();
        send_byte(8'h85, ack);
        check_output("t3_read_nack", 32'(ack), 32'd0);
        send_byte(8'h22, ack);
        check_output("t3_ignored_nack", 32'(ack), 32'd0);
        check_output("t3_busy", 32'(BUSY), 32'd1);
        check_output("t3_addrhit", 32'(ADDRHIT), 32'd0);
        i2c_stop();
        check_output("t3_pull_cycles", 32'(pull_cnt - p0), 32'd0);

        $display("[TB] 3-cycle SDA glitch while SCL high");
        sda_drv = 1'b0;
        wait_clk(3);
        sda_drv = 1'b1;
        wait_clk(20);
        check_output("t4_glitch_busy", 32'(BUSY), 32'd0);

        $display("[TB] repeated start inside a data byte");
        i2c_start();
        send_byte(8'h84, ack);
        check_output("t5_addr_ack", 32'(ack), 32'd1);
        i2c_bit(1'b1);
        i2c_bit(1'b1);
        i2c_bit(1'b0);
        i2c_bit(1'b0);
        v0 = valid_cnt;
        i2c_start();
        check_output("t5_addrhit_cleared", 32'(ADDRHIT), 32'd0);
        check_output("t5_rxcount_cleared", 32'(RXCOUNT), 32'd0);
        send_byte(8'h84, ack);
        check_output("t5_readdr_ack", 32'(ack), 32'd1);
        send_byte(8'h5A, ack);
        check_output("t5_data_ack", 32'(ack), 32'd1);
        check_output("t5_rxcount", 32'(RXCOUNT), 32'd1);
        check_output("t5_rxdata", 32'(RXDATA), 32'h5A);
        check_output("t5_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        i2c_stop();

`ifdef I2C_TGT_FRAME_EN
        $display("[TB] frame assembly 0x12 0x34 0x56 0x78");
        f0 = fv_cnt;
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'h12, ack);
        send_byte(8'h34, ack);
        send_byte(8'h56, ack);
        check_output("t6_frame", 32'(FRAME), 32'h123456);
        send_byte(8'h78, ack);
        check_output("t6_frame_hold", 32'(FRAME), 32'h123456);
        check_output("t6_frame_pulses", 32'(fv_cnt - f0), 32'd1);
        check_output("t6_rxcount", 32'(RXCOUNT), 32'd4);
        i2c_stop();
`else
        f0 = fv_cnt;
`endif

        $display("[TB] reset asserted during an ACK slot");
        i2c_start();
        send_byte(8'h84, ack);
        send_byte(8'h12, ack);
        for (int i = 7; i >= 0; i--) i2c_bit(1'(8'h34 >> i));
        sda_drv = 1'b1;
        wait_clk(2);
        check_output("t7_pull_before_reset", 32'(SDA_PULL), 32'd1);
        RESET   = 1'b1;
        scl_drv = 1'b1;
        wait_clk(2);
        check_output("t7_pull", 32'(SDA_PULL), 32'd0);
        check_output("t7_rxdata", 32'(RXDATA), 32'd0);
        check_output("t7_rxcount", 32'(RXCOUNT), 32'd0);
        check_output("t7_addrhit", 32'(ADDRHIT), 32'd0);
        check_output("t7_busy", 32'(BUSY), 32'd0);
`ifdef I2C_TGT_FRAME_EN
        check_output("t7_frame", 32'(FRAME), 32'd0);
        check_output("t7_framevalid", 32'(FRAMEVALID), 32'd0);
`endif
        wait_clk(5);
        RESET = 1'b0;
        wait_clk(20);
        check_output("t7_idle_after_reset", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
